mem_port_arbiter: RTL

- Round-robin arbiter that shares one 64-bit memory port among four requesters (e.g. IF, MEM, debug, DMA).
- Drives the 2-bit select of the shared 4-to-1 64-bit mux that steers address and write data onto the port.
- Sequences one transaction at a time: grant, issue, wait for response, route the response back.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of one shared memory port across four requesters
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [3:0]          req_valid,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  input  logic [3:0]          req_we,
  output logic [3:0]          req_ready,
  output logic [3:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          sel,
  output logic [3:0]          grant,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr, rr_ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] grant_nxt;
  logic [3:0] sel_oh;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  // Scan from the farthest offset back to rr_ptr so the nearest requester wins.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_oh     = 4'b0001 << sel;
  assign mem_addr   = req_addr[32'(sel) * ADDR_W +: ADDR_W];
  assign mem_wdata  = req_wdata[32'(sel) * DATA_W +: DATA_W];
  assign mem_we     = req_we[sel];
  assign resp_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      rr_ptr <= 2'd0;
      sel    <= 2'd0;
      grant  <= 4'd0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      sel    <= sel_nxt;
      grant  <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    sel_nxt       = sel;
    grant_nxt     = grant;
    mem_req_valid = 1'b0;
    req_ready     = 4'd0;
    resp_valid    = 4'd0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt   = pick;
          grant_nxt = 4'b0001 << pick;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          req_ready = sel_oh;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Response routing is combinational so the owner sees it in the same cycle.
        if (mem_resp_valid) begin
          resp_valid = sel_oh;
          rr_ptr_nxt = sel + 2'd1;
          grant_nxt  = 4'd0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
